// File: rtl/sprite_image_loader_pkg.sv
// Shared definitions for the sprite image loader and the renderers that read the same RAM.
// Holds the FSM state encoding and the default sprite geometry.
package sprite_image_loader_pkg;

  localparam int unsigned SpriteWidth  = 180;
  localparam int unsigned SpriteHeight = 180;
  localparam int unsigned SpriteAddrW  = 20;
  localparam int unsigned SpriteDataW  = 8;
  localparam int unsigned ColW         = 11;
  localparam int unsigned RowW         = 10;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2
  } loader_state_e;

endpackage

// File: rtl/sprite_image_loader_raster_addr_counter.sv
// Raster position counter: col/row plus a linear address kept equal to col + row*Width
// by incrementing alongside col, so no multiplier is needed.
module sprite_image_loader_raster_addr_counter
  import sprite_image_loader_pkg::*;
#(
  parameter int unsigned Width  = SpriteWidth,
  parameter int unsigned Height = SpriteHeight,
  parameter int unsigned AddrW  = SpriteAddrW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             step_i,
  output logic [ColW-1:0]  col_o,
  output logic [RowW-1:0]  row_o,
  output logic [AddrW-1:0] addr_o,
  output logic             last_o
);

  logic [ColW-1:0]  col_q, col_d;
  logic [RowW-1:0]  row_q, row_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic             col_end;

  assign col_end = (col_q == ColW'(Width - 1));
  assign last_o  = col_end && (row_q == RowW'(Height - 1));

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (clear_i) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (step_i) begin
      if (last_o) begin
        // Wrap to the origin so the next load starts clean.
        col_d  = '0;
        row_d  = '0;
        addr_d = '0;
      end else if (col_end) begin
        col_d  = '0;
        row_d  = row_q + RowW'(1);
        addr_d = addr_q + AddrW'(1);
      end else begin
        col_d  = col_q + ColW'(1);
        addr_d = addr_q + AddrW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/sprite_image_loader.sv
// Streams palette indices (valid/ready) into the write port of the sprite image RAM in
// raster order, one registered write per accepted byte.
module sprite_image_loader
  import sprite_image_loader_pkg::*;
#(
  parameter int unsigned Width  = SpriteWidth,
  parameter int unsigned Height = SpriteHeight,
  parameter int unsigned AddrW  = SpriteAddrW,
  parameter int unsigned DataW  = SpriteDataW
) (
  input  logic             pixel_clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             hold_off_i,
  input  logic [DataW-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [DataW-1:0] mem_din_o,
  output logic             mem_we_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [ColW-1:0]  col_o,
  output logic [RowW-1:0]  row_o
);

  loader_state_e    state_q, state_d;
  logic             accept, clear, last;
  logic [AddrW-1:0] cnt_addr;
  logic [AddrW-1:0] mem_addr_q;
  logic [DataW-1:0] mem_din_q;
  logic             mem_we_q;

  assign in_ready_o = (state_q == StLoad) && !hold_off_i;
  // A byte handshaken in the abort cycle is dropped.
  assign accept     = in_valid_i && in_ready_o && !abort_i;
  assign clear      = abort_i || ((state_q == StIdle) && start_i);

  sprite_image_loader_raster_addr_counter #(
    .Width  (Width),
    .Height (Height),
    .AddrW  (AddrW)
  ) u_counter (
    .clk_i   (pixel_clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear),
    .step_i  (accept),
    .col_o   (col_o),
    .row_o   (row_o),
    .addr_o  (cnt_addr),
    .last_o  (last)
  );

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (start_i) state_d = StLoad;
        StLoad:  if (accept && last) state_d = StDone;
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge pixel_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      state_q  <= state_d;
      mem_we_q <= accept;
      if (accept) begin
        mem_addr_q <= cnt_addr;
        mem_din_q  <= in_data_i;
      end
    end
  end

  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_din_o  = mem_din_q;
  assign busy_o     = (state_q == StLoad);
  assign done_o     = (state_q == StDone);

endmodule

// File: doc/sprite_image_loader.md
Name: sprite_image_loader

Overview:
Writer-side counterpart of the sprite renderers. Accepts a byte stream of palette indices (valid/ready) and writes it raster-order into the write port of a dual-port sprite image RAM. Address mapping is identical to the renderer's read mapping, addr = col + row*WIDTH. The renderers read that RAM through its other port. Used to replace sprite art at run time, e.g. from a UART or host link.

Parameters:
WIDTH, 180, sprite width in pixels
HEIGHT, 180, sprite height in pixels
ADDR_W, 20, RAM address width; must satisfy WIDTH*HEIGHT <= 2**ADDR_W
DATA_W, 8, palette index width

Ports:
pixel_clk  in  1  sole clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a full-image load
abort  in  1  one-cycle pulse; cancels the load in progress
hold_off  in  1  when 1, the block refuses data (e.g. during active display)
in_data  in  DATA_W  palette index
in_valid  in  1  in_data is valid
in_ready  out  1  block accepts in_data this cycle
mem_addr  out  ADDR_W  RAM write address
mem_din  out  DATA_W  RAM write data
mem_we  out  1  RAM write enable
busy  out  1  high while in LOAD
done  out  1  one-cycle pulse when the last pixel write is issued
col  out  11  current column (next pixel to accept)
row  out  10  current row (next pixel to accept)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready, mem_we, busy, done = 0; mem_addr, mem_din, col, row = 0.
- States:
  - IDLE: in_ready=0; in_valid is ignored. start -> LOAD and clears col, row and the address counter.
  - LOAD: busy=1; in_ready = ~hold_off (combinational).
  - DONE: one cycle; done=1; then -> IDLE.
- Transfer occurs when in_valid & in_ready. In the following cycle: mem_we=1, mem_addr = address of the accepted pixel, mem_din = the accepted byte. Fixed write latency is 1 cycle. mem_we is 0 in every cycle that does not follow a transfer.
- Address: incremental counter, no multiplier. After each transfer it increments by 1, and col increments. When col==WIDTH-1, col wraps to 0 and row increments. The invariant mem_addr == col + row*WIDTH holds at every write.
- Last pixel: a transfer at row==HEIGHT-1, col==WIDTH-1 moves the state LOAD -> DONE. Its write issues in the DONE cycle, the same cycle done=1. col and row return to 0.
- Back-to-back: in LOAD with in_valid held high and hold_off=0, the block accepts one pixel per cycle. A full image takes WIDTH*HEIGHT cycles.
- hold_off rises mid-frame: in_ready drops the same cycle and the position is preserved. The load resumes at the same col/row when hold_off falls.
- abort, in any state: -> IDLE next cycle; busy=0; no done pulse. A transfer in the abort cycle is discarded: no write follows. abort and start in the same cycle: abort wins.
- start while in LOAD or DONE: ignored.
- Reset mid-load: immediate return to reset values. RAM contents are undefined/partial; no write issues after reset.

Decomposition:
- Shared package: state encoding (IDLE/LOAD/DONE) and the sprite geometry constants (WIDTH/HEIGHT/ADDR_W defaults) reused by the renderers.
- One natural sub-module, raster_addr_counter: col/row/address counter with wrap and last-pixel flag. The same counter can drive renderer self-test.

Test Plan:
- WIDTH=4, HEIGHT=3; reset then start; stream bytes 0..11 with in_valid held 1 -> mem_we high for 12 consecutive cycles starting 1 cycle after the first transfer; addresses 0..11 with mem_din == addr; done pulses once, with the addr-11 write; busy falls after.
- Same config; hold_off=1 for 3 cycles after pixel 5 -> in_ready=0 and no writes during hold; resume writes addr 6 with the correct byte; col=2, row=1 during the hold.
- Bursty in_valid (random gaps) -> write sequence still addr 0..11 in order; no duplicates or skips; done after the 12th transfer only.
- abort after pixel 7 while in_valid is high -> no write for the abort-cycle byte; busy=0 next cycle; no done. A new start writes again from addr 0.
- start asserted during LOAD, and start together with abort -> first ignored (col/row unchanged); second yields IDLE.
- rst_n dropped asynchronously mid-load (between clock edges) -> all outputs 0 immediately; in_ready=0; no mem_we until the next start.
